// File: rtl/eq_band_mixer_pkg.sv
// Shared constants and FSM state type for the equalizer band mixer.
package eq_pkg;
  localparam int N_BAND = 5;
  localparam int DW     = 16;
  localparam int GW     = 16;
  localparam int FRAC   = 14;
  localparam int ACC_W  = 36;
  localparam int PROD_W = DW + GW + 1;
  localparam int KW     = 3;

  localparam logic [GW-1:0] GAIN_UNITY = 16'h4000;

  typedef enum logic [1:0] {IDLE, MAC, SAT} state_t;
endpackage

// File: rtl/eq_band_mixer_if.sv
// Sample, gain-programming and status bundle of the band mixer.
interface eq_band_mixer_if;
  import eq_pkg::*;

  logic                     in_valid;
  logic [N_BAND*DW-1:0]     band_in;
  logic                     gain_we;
  logic [KW-1:0]            gain_addr;
  logic [GW-1:0]            gain_wdata;
  logic                     ovr_clr;
  logic signed [DW-1:0]     y_out;
  logic                     y_valid;
  logic                     clip;
  logic                     busy;
  logic                     overrun;

  modport master (
    output in_valid, band_in, gain_we, gain_addr, gain_wdata, ovr_clr,
    input  y_out, y_valid, clip, busy, overrun
  );

  modport slave (
    input  in_valid, band_in, gain_we, gain_addr, gain_wdata, ovr_clr,
    output y_out, y_valid, clip, busy, overrun
  );
endinterface

// File: rtl/eq_sat_round.sv
// Round-half-up, arithmetic right shift by FRAC and clamp of the MAC sum to DW bits.
module eq_sat_round
  import eq_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y,
  output logic                    clip
);
  localparam int RW = ACC_W - FRAC;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC - 1));
  localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] biased;
  logic signed [RW-1:0]    r;

  // The bias cannot overflow: |acc| stays well below 2^(ACC_W-1) for N_BAND bands.
  assign biased = acc + HALF;
  assign r      = biased[ACC_W-1:FRAC];

  always_comb begin
    y    = r[DW-1:0];
    clip = 1'b0;
    if (r > MAXV) begin
      y    = {1'b0, {(DW-1){1'b1}}};
      clip = 1'b1;
    end else if (r < MINV) begin
      y    = {1'b1, {(DW-1){1'b0}}};
      clip = 1'b1;
    end
  end
endmodule

// File: rtl/eq_band_mixer.sv
// Gain-and-sum stage: snapshots band samples and gains, runs a time-shared MAC, then rounds and saturates.
module eq_band_mixer
  import eq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  eq_band_mixer_if.slave  bus
);
  state_t                   state;
  logic [KW-1:0]            k;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DW-1:0]     xs   [N_BAND];
  logic [GW-1:0]            gs   [N_BAND];
  logic [GW-1:0]            gain [N_BAND];
  logic signed [PROD_W-1:0] prod;
  logic signed [DW-1:0]     sat_y;
  logic                     sat_clip;

  // Gain is unsigned Q2.14, so a zero MSB turns it into a non-negative signed operand.
  assign prod = xs[k] * $signed({1'b0, gs[k]});

  eq_sat_round u_sat (
    .acc  (acc),
    .y    (sat_y),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      acc         <= '0;
      bus.y_out   <= '0;
      bus.y_valid <= 1'b0;
      bus.clip    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.overrun <= 1'b0;
      // NOTE: these small register arrays get a defined reset value; gains must come up at unity.
      for (int i = 0; i < N_BAND; i++) begin
        xs[i]   <= '0;
        gs[i]   <= '0;
        gain[i] <= GAIN_UNITY;
      end
    end else begin
      bus.y_valid <= 1'b0;
      bus.clip    <= 1'b0;

      if (bus.gain_we && (bus.gain_addr < KW'(N_BAND)))
        gain[bus.gain_addr] <= bus.gain_wdata;

      if (bus.in_valid && (state != IDLE))
        bus.overrun <= 1'b1;
      else if (bus.ovr_clr)
        bus.overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_BAND; i++) begin
              xs[i] <= $signed(bus.band_in[i*DW +: DW]);
              gs[i] <= gain[i];
            end
            acc      <= '0;
            k        <= '0;
            bus.busy <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          if (k == KW'(N_BAND - 1))
            state <= SAT;
          else
            k <= k + KW'(1);
        end
        SAT: begin
          bus.y_out   <= sat_y;
          bus.clip    <= sat_clip;
          bus.y_valid <= 1'b1;
          bus.busy    <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eq_band_mixer.sv
// Self-checking bench: vector table, hand-written corner sequences and random samples against a sum-of-products model.
module tb_eq_band_mixer;
  import eq_pkg::*;

  typedef int arr5_t [N_BAND];

  typedef struct {
    arr5_t x;
    arr5_t g;
    int    y;
    bit    c;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  arr5_t mg;

  eq_band_mixer_if bus ();

  eq_band_mixer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Sum of x*g, then floor(sum/2^14 + 1/2), then clamp to the 16-bit signed range.
  function automatic void ref_mix(input arr5_t x, input arr5_t g, output int y, output bit c);
    longint s = 0;
    longint q;
    for (int i = 0; i < N_BAND; i++) s += longint'(x[i]) * longint'(g[i]);
    s += 8192;
    if (s >= 0) q = s / 16384;
    else        q = -((-s + 16383) / 16384);
    c = 1'b0;
    if (q > 32767)       begin q = 32767;  c = 1'b1; end
    else if (q < -32768) begin q = -32768; c = 1'b1; end
    y = int'(q);
  endfunction

  function automatic logic [N_BAND*DW-1:0] pack(input arr5_t x);
    logic [N_BAND*DW-1:0] p;
    for (int i = 0; i < N_BAND; i++) p[i*DW +: DW] = x[i][DW-1:0];
    return p;
  endfunction

  task automatic write_gain(input int addr, input int data);
    @(negedge clk);
    bus.gain_we    = 1'b1;
    bus.gain_addr  = KW'(addr);
    bus.gain_wdata = GW'(data);
    @(negedge clk);
    bus.gain_we = 1'b0;
    if (addr < N_BAND) mg[addr] = data & 'hFFFF;
  endtask

  task automatic set_gains(input arr5_t g);
    for (int i = 0; i < N_BAND; i++) write_gain(i, g[i]);
  endtask

  // Returns at the falling edge just after the accepting edge E0.
  task automatic start_sample(input arr5_t x);
    @(negedge clk);
    bus.band_in  = pack(x);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat0 = number of rising edges already elapsed since E0.
  task automatic finish_sample(input int lat0, input int ey, input bit ec, input string name);
    int lat;
    lat = lat0;
    while (!bus.y_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "/latency"}, lat, 6);
    check({name, "/y_out"}, longint'(bus.y_out), ey);
    check({name, "/clip"}, bus.clip, ec);
    @(negedge clk);
    check({name, "/y_valid_pulse"}, bus.y_valid, 0);
    check({name, "/clip_pulse"}, bus.clip, 0);
    check({name, "/busy_low"}, bus.busy, 0);
  endtask

  task automatic run_sample(input arr5_t x, input int ey, input bit ec, input string name);
    start_sample(x);
    check({name, "/busy_high"}, bus.busy, 1);
    finish_sample(0, ey, ec, name);
  endtask

  task automatic run_model(input arr5_t x, input string name);
    int ey;
    bit ec;
    ref_mix(x, mg, ey, ec);
    run_sample(x, ey, ec, name);
  endtask

  localparam int U = 'h4000;

  initial begin
    vec_t  vecs [12];
    arr5_t x;
    arr5_t unity;
    bit    yv_seen;

    vecs[0]  = '{'{1000, 2000, -500, 0, 100}, '{U, U, U, U, U}, 2600, 1'b0, "unity_mix"};
    vecs[1]  = '{'{32767, 32767, 32767, 32767, 32767}, '{U, U, U, U, U}, 32767, 1'b1, "pos_sat"};
    vecs[2]  = '{'{-32768, -32768, -32768, -32768, -32768}, '{U, U, U, U, U}, -32768, 1'b1, "neg_sat"};
    vecs[3]  = '{'{3, 0, 0, 0, 0}, '{'h2000, 0, 0, 0, 0}, 2, 1'b0, "round_p3"};
    vecs[4]  = '{'{-3, 0, 0, 0, 0}, '{'h2000, 0, 0, 0, 0}, -1, 1'b0, "round_m3"};
    vecs[5]  = '{'{1, 0, 0, 0, 0}, '{'h2000, 0, 0, 0, 0}, 1, 1'b0, "round_p1"};
    vecs[6]  = '{'{-1, 0, 0, 0, 0}, '{'h2000, 0, 0, 0, 0}, 0, 1'b0, "round_m1"};
    vecs[7]  = '{'{-1000, 300, 7, 7, 7}, '{'h8000, U, 0, 0, 0}, -1700, 1'b0, "gain_two"};
    vecs[8]  = '{'{1, 1, 1, 1, 1}, '{'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF}, 20, 1'b0, "max_gain"};
    vecs[9]  = '{'{32767, 0, 0, 0, 0}, '{U, U, U, U, U}, 32767, 1'b0, "edge_max"};
    vecs[10] = '{'{32767, 1, 0, 0, 0}, '{U, U, U, U, U}, 32767, 1'b1, "edge_max_p1"};
    vecs[11] = '{'{-32768, -1, 0, 0, 0}, '{U, U, U, U, U}, -32768, 1'b1, "edge_min_m1"};
    unity    = '{U, U, U, U, U};

    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.band_in    = '0;
    bus.gain_we    = 1'b0;
    bus.gain_addr  = '0;
    bus.gain_wdata = '0;
    bus.ovr_clr    = 1'b0;
    mg             = unity;

    repeat (3) @(negedge clk);
    check("rst/y_out", longint'(bus.y_out), 0);
    check("rst/y_valid", bus.y_valid, 0);
    check("rst/clip", bus.clip, 0);
    check("rst/busy", bus.busy, 0);
    check("rst/overrun", bus.overrun, 0);
    rst_n = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      set_gains(vecs[i].g);
      run_sample(vecs[i].x, vecs[i].y, vecs[i].c, vecs[i].name);
    end

    // Gain write landing on E3 only affects the next sample.
    set_gains(unity);
    x = '{100, 100, 100, 100, 100};
    start_sample(x);
    @(negedge clk);
    @(negedge clk);
    bus.gain_we    = 1'b1;
    bus.gain_addr  = 3'd2;
    bus.gain_wdata = '0;
    @(negedge clk);
    bus.gain_we = 1'b0;
    mg[2] = 0;
    finish_sample(3, 500, 1'b0, "midwrite_cur");
    run_sample(x, 400, 1'b0, "midwrite_next");
    write_gain(2, U);

    // Drop during MAC, together with ovr_clr: the set takes priority.
    x = '{10, 20, 30, 40, 50};
    start_sample(x);
    @(negedge clk);
    @(negedge clk);
    bus.band_in  = pack('{1000, 1000, 1000, 1000, 1000});
    bus.in_valid = 1'b1;
    bus.ovr_clr  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.ovr_clr  = 1'b0;
    check("ovr/set_wins", bus.overrun, 1);
    finish_sample(3, 150, 1'b0, "ovr_result");
    repeat (3) @(negedge clk);
    check("ovr/sticky", bus.overrun, 1);
    bus.ovr_clr = 1'b1;
    @(negedge clk);
    bus.ovr_clr = 1'b0;
    check("ovr/cleared", bus.overrun, 0);

    // Writes to out-of-range addresses leave the gain file untouched.
    write_gain(5, 0);
    write_gain(7, 0);
    run_sample('{100, 100, 100, 100, 100}, 500, 1'b0, "bad_addr");

    // Reset at E4 abandons the sample and restores unity gains.
    write_gain(1, 'h1000);
    start_sample('{100, 100, 100, 100, 100});
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    mg      = unity;
    yv_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.y_valid) yv_seen = 1'b1;
    end
    check("midrst/no_y_valid", yv_seen, 0);
    check("midrst/y_out", longint'(bus.y_out), 0);
    check("midrst/busy", bus.busy, 0);
    run_sample('{100, 100, 100, 100, 100}, 500, 1'b0, "midrst_after");

    // Random gains (including ignored addresses) and samples against the model.
    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) write_gain($urandom_range(0, 7), $urandom_range(0, 'hFFFF));
      for (int i = 0; i < N_BAND; i++) begin
        logic [15:0] r16;
        r16 = 16'($urandom);
        if ($urandom_range(0, 3) == 0) r16 = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
        x[i] = int'($signed(r16));
      end
      run_model(x, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
